dds_sweep_ctrl: RTL and testbench

//   Sequencer for the dds_wave core: drives its frequency word K and phase word P.

---
 rtl/dds_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency/phase sweep sequencer for the dds_wave core.
// Steps K through single-up, sawtooth or triangle sweeps with a per-word dwell.
module dds_sweep_ctrl #(
  parameter int unsigned KW = 32,
  parameter int unsigned PW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          abort,
  output logic [KW-1:0] dds_k,
  output logic [PW-1:0] dds_p,
  output logic          dds_upd,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {StIdle, StLoad, StDwell, StStep, StDone} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_start_q, k_stop_q, k_step_q;
  logic [DW-1:0] dwell_q;
  logic [PW-1:0] phase_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          dir_down_q, dir_down_d;
  logic [KW-1:0] dds_k_q, dds_k_d;
  logic [PW-1:0] dds_p_q, dds_p_d;
  logic          upd_q, upd_d;
  logic          err_q, err_d;

  logic          cfg_acc;
  logic [KW-1:0] eff_start, eff_stop, eff_step;
  logic [KW:0]   up_sum, dn_diff;
  logic [KW-1:0] up_nxt, dn_nxt, nxt_k;
  logic          do_upd;

  assign cfg_ready = (state_q == StIdle);
  assign cfg_acc   = cfg_valid & cfg_ready;

  // A start coinciding with a config accept must see the incoming values.
  assign eff_start = cfg_acc ? cfg_k_start : k_start_q;
  assign eff_stop  = cfg_acc ? cfg_k_stop  : k_stop_q;
  assign eff_step  = cfg_acc ? cfg_k_step  : k_step_q;

  assign up_sum  = {1'b0, dds_k_q} + {1'b0, k_step_q};
  assign dn_diff = {1'b0, dds_k_q} - {1'b0, k_step_q};
  assign up_nxt  = (up_sum[KW] || (up_sum[KW-1:0] > k_stop_q)) ? k_stop_q : up_sum[KW-1:0];
  assign dn_nxt  = (dn_diff[KW] || (dn_diff[KW-1:0] < k_start_q)) ? k_start_q
                                                                   : dn_diff[KW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    dds_k_d    = dds_k_q;
    dds_p_d    = dds_p_q;
    upd_d      = 1'b0;
    err_d      = cfg_acc ? 1'b0 : err_q;
    do_upd     = 1'b0;
    nxt_k      = dds_k_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((eff_start > eff_stop) || (eff_step == '0)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        do_upd     = 1'b1;
        nxt_k      = k_start_q;
        dds_p_d    = phase_q;
        dir_down_d = 1'b0;
      end
      StDwell: begin
        if (cnt_q == '0) state_d = StStep;
        else             cnt_d   = cnt_q - DW'(1);
      end
      StStep: begin
        if (!dir_down_q) begin
          if (dds_k_q == k_stop_q) begin
            case (mode_q)
              2'b01: begin
                do_upd = 1'b1;
                nxt_k  = k_start_q;
              end
              2'b10: begin
                do_upd     = 1'b1;
                dir_down_d = 1'b1;
                nxt_k      = dn_nxt;
              end
              default: state_d = StDone;
            endcase
          end else begin
            do_upd = 1'b1;
            nxt_k  = up_nxt;
          end
        end else begin
          do_upd = 1'b1;
          if (dds_k_q == k_start_q) begin
            dir_down_d = 1'b0;
            nxt_k      = up_nxt;
          end else begin
            nxt_k = dn_nxt;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The update cycle counts toward the hold time, so the counter starts at dwell-1
    // and a zero dwell goes straight back to STEP.
    if (do_upd) begin
      dds_k_d = nxt_k;
      upd_d   = 1'b1;
      cnt_d   = dwell_q - DW'(1);
      state_d = (dwell_q == '0) ? StStep : StDwell;
    end

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      cnt_d      = cnt_q;
      dir_down_d = dir_down_q;
      dds_k_d    = dds_k_q;
      dds_p_d    = dds_p_q;
      upd_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      dds_k_q    <= '0;
      dds_p_q    <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      k_start_q  <= '0;
      k_stop_q   <= '0;
      k_step_q   <= '0;
      dwell_q    <= '0;
      phase_q    <= '0;
      mode_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      dds_k_q    <= dds_k_d;
      dds_p_q    <= dds_p_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      if (cfg_acc) begin
        k_start_q <= cfg_k_start;
        k_stop_q  <= cfg_k_stop;
        k_step_q  <= cfg_k_step;
        dwell_q   <= cfg_dwell;
        phase_q   <= cfg_phase;
        mode_q    <= cfg_mode;
      end
    end
  end

  assign dds_k   = dds_k_q;
  assign dds_p   = dds_p_q;
  assign dds_upd = upd_q;
  assign busy    = (state_q == StLoad) || (state_q == StDwell) || (state_q == StStep);
  assign done    = (state_q == StDone);
  assign err     = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed word sequences, checked on falling edges.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_k_start = '0, cfg_k_stop = '0, cfg_k_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic [10:0] cfg_phase = '0;
  logic [1:0]  cfg_mode = '0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] dds_k;
  logic [10:0] dds_p;
  logic        dds_upd, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  dds_sweep_ctrl #(.KW(32), .PW(11), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_k_start(cfg_k_start), .cfg_k_stop(cfg_k_stop), .cfg_k_step(cfg_k_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .start(start), .abort(abort),
    .dds_k(dds_k), .dds_p(dds_p), .dds_upd(dds_upd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL timeout: observed no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [31:0] k, input logic u,
                         input logic b, input logic d);
    chk({tag, " dds_k"}, 64'(dds_k), 64'(k));
    chk({tag, " dds_upd"}, 64'(dds_upd), 64'(u));
    chk({tag, " busy"}, 64'(busy), 64'(b));
    chk({tag, " done"}, 64'(done), 64'(d));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [31:0] ks, input logic [31:0] kp, input logic [31:0] kt,
                         input logic [15:0] dw, input logic [10:0] ph, input logic [1:0] md);
    cfg_k_start = ks;
    cfg_k_stop  = kp;
    cfg_k_step  = kt;
    cfg_dwell   = dw;
    cfg_phase   = ph;
    cfg_mode    = md;
  endtask

  logic [31:0] t2k[4] = '{32'd0, 32'd10, 32'd20, 32'd25};
  logic [31:0] t3k[7] = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
  logic [31:0] t4k[5] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF,
                          32'hFFFF_FFF0};

  initial begin
    logic [31:0] k;

    // Reset state
    #3;
    chk_cyc("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    chk("reset dds_p", 64'(dds_p), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    rst_n = 1'b1;

    // 1: single-up 100..130 step 10 dwell 2, config accepted with start
    set_cfg(32'd100, 32'd130, 32'd10, 16'd2, 11'h7FF, 2'b00);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    chk_cyc("t1 load", 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t1 cfg_ready", 64'(cfg_ready), 64'd0);
    for (int i = 0; i <= 12; i++) begin
      tick();
      k = 32'(100 + 10 * ((i / 3 > 3) ? 3 : i / 3));
      chk_cyc($sformatf("t1 c%0d", i), k, (i % 3 == 0) && (i <= 9), i < 12, i == 12);
      if (i == 0) chk("t1 dds_p", 64'(dds_p), 64'h7FF);
    end
    tick();
    chk_cyc("t1 after", 32'd130, 1'b0, 1'b0, 1'b0);

    // 2: clamp at stop, config accepted before start
    set_cfg(32'd0, 32'd25, 32'd10, 16'd0, 11'd0, 2'b00);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_cyc("t2 load", 32'd130, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cyc($sformatf("t2 w%0d", i), t2k[i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_cyc("t2 done", 32'd25, 1'b0, 1'b0, 1'b1);
    tick();
    chk_cyc("t2 idle", 32'd25, 1'b0, 1'b0, 1'b0);
    chk("t2 dds_p", 64'(dds_p), 64'd0);

    // 3: triangle 0..20 step 10, then abort
    set_cfg(32'd0, 32'd20, 32'd10, 16'd0, 11'h123, 2'b10);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    chk_cyc("t3 load", 32'd25, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_cyc($sformatf("t3 w%0d", i), t3k[i], 1'b1, 1'b1, 1'b0);
    end
    chk("t3 dds_p", 64'(dds_p), 64'h123);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_cyc("t3 abort", 32'd20, 1'b0, 1'b0, 1'b0);
    chk("t3 cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    chk_cyc("t3 post", 32'd20, 1'b0, 1'b0, 1'b0);

    // 4: sawtooth near the top of the range, carry clamp
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd0, 11'd0, 2'b01);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    chk_cyc("t4 load", 32'd20, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cyc($sformatf("t4 w%0d", i), t4k[i], 1'b1, 1'b1, 1'b0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_cyc("t4 abort", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);

    // 5: config errors
    set_cfg(32'd50, 32'd40, 32'd1, 16'd0, 11'd0, 2'b00);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    chk_cyc("t5a done", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
    chk("t5a err", 64'(err), 64'd1);
    tick();
    chk_cyc("t5a idle", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    chk("t5a err sticky", 64'(err), 64'd1);
    set_cfg(32'd10, 32'd40, 32'd0, 16'd0, 11'd0, 2'b00);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    chk_cyc("t5b done", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
    chk("t5b err", 64'(err), 64'd1);
    tick();
    set_cfg(32'd10, 32'd40, 32'd5, 16'd0, 11'd0, 2'b00);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("t5c err cleared", 64'(err), 64'd0);
    chk_cyc("t5c idle", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);

    // 6: config refused while busy, then async reset mid-sweep
    set_cfg(32'd100, 32'd200, 32'd1, 16'd5, 11'd0, 2'b00);
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    tick();
    chk_cyc("t6 first", 32'd100, 1'b1, 1'b1, 1'b0);
    tick();
    set_cfg(32'd500, 32'd600, 32'd7, 16'd0, 11'd0, 2'b00);
    cfg_valid = 1'b1;
    tick();
    chk("t6 ready busy a", 64'(cfg_ready), 64'd0);
    tick();
    chk("t6 ready busy b", 64'(cfg_ready), 64'd0);
    cfg_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_cyc("t6 abort", 32'd100, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_cyc("t6 restart", 32'd100, 1'b1, 1'b1, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_cyc("t6 rst", 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t6 rst cfg_ready", 64'(cfg_ready), 64'd1);
    chk("t6 rst err", 64'(err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_cyc("t6 post rst", 32'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
